// File: rtl/fma_sign_ctrl.sv
// -----------------------------------------------------------------------------
// fma_sign_ctrl
//
// Pipelined sign-control unit for the single-precision FMA datapath. For each
// lane it folds the fused-operation mode into the operand signs:
//   sign_P  = sign_A ^ sign_B ^ op[1]   (op[1] negates the product)
//   sign_Ce = sign_C ^ op[0]            (op[0] negates the addend)
// It also produces the two's-complement enable pair {sign_Ce, sign_P} and the
// effective-subtract flag sign_P ^ sign_Ce.
//
// LANES lanes share one valid/ready handshake and travel through STAGES
// register stages. Empty stages (bubbles) are collapsed, so the pipe keeps
// accepting work under backpressure until every stage is occupied.
//
// Parameters
//   LANES   number of parallel lanes (>= 1)
//   STAGES  register stages from input to output (>= 1)
//   TAG_W   width of the opaque sideband tag (>= 1)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input transaction present
//   in_ready   unit accepts the input this cycle (combinational from out_ready)
//   sign_A     multiplicand sign per lane
//   sign_B     multiplier sign per lane
//   sign_C     addend sign per lane
//   op         mode per lane, lane i uses op[2i+1:2i]
//   in_tag     sideband tag
//   out_valid  output transaction present
//   out_ready  consumer accepts the output this cycle
//   sign_P     effective product sign per lane
//   sign_Ce    effective addend sign per lane
//   two_en     lane i: two_en[2i+1:2i] = {sign_Ce[i], sign_P[i]}
//   eff_sub    effective subtract per lane
//   out_tag    tag of the transaction on the outputs
// -----------------------------------------------------------------------------
module fma_sign_ctrl #(
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES-1:0]     sign_A,
    input  logic [LANES-1:0]     sign_B,
    input  logic [LANES-1:0]     sign_C,
    input  logic [2*LANES-1:0]   op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     sign_P,
    output logic [LANES-1:0]     sign_Ce,
    output logic [2*LANES-1:0]   two_en,
    output logic [LANES-1:0]     eff_sub,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int LAST = STAGES - 1;

    // -------------------------------------------------------------------------
    // Per-lane sign helpers
    // -------------------------------------------------------------------------

    // Product sign: XOR of the operand signs, optionally negated by op[2i+1].
    function automatic logic [LANES-1:0] calc_sign_p(
        input logic [LANES-1:0]   a,
        input logic [LANES-1:0]   b,
        input logic [2*LANES-1:0] m
    );
        logic [LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i] = a[i] ^ b[i] ^ m[2*i+1];
        end
        return r;
    endfunction

    // Effective addend sign: addend sign optionally negated by op[2i].
    function automatic logic [LANES-1:0] calc_sign_ce(
        input logic [LANES-1:0]   c,
        input logic [2*LANES-1:0] m
    );
        logic [LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i] = c[i] ^ m[2*i];
        end
        return r;
    endfunction

    // Interleave the two sign vectors into the per-lane enable pair
    // {sign_Ce, sign_P}; this is the layout the legacy decoder produced.
    function automatic logic [2*LANES-1:0] calc_two_en(
        input logic [LANES-1:0] p,
        input logic [LANES-1:0] ce
    );
        logic [2*LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[2*i]   = p[i];
            r[2*i+1] = ce[i];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Entry computation (stage 0 input)
    // -------------------------------------------------------------------------
    logic [LANES-1:0]   ent_sp_s;
    logic [LANES-1:0]   ent_sce_s;
    logic [2*LANES-1:0] ent_te_s;
    logic [LANES-1:0]   ent_es_s;

    assign ent_sp_s  = calc_sign_p(sign_A, sign_B, op);
    assign ent_sce_s = calc_sign_ce(sign_C, op);
    assign ent_te_s  = calc_two_en(ent_sp_s, ent_sce_s);
    // Effective subtract is set exactly when the enable pair is 01 or 10.
    assign ent_es_s  = ent_sp_s ^ ent_sce_s;

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic               v_q   [STAGES];
    logic               v_d   [STAGES];
    logic [LANES-1:0]   sp_q  [STAGES];
    logic [LANES-1:0]   sp_d  [STAGES];
    logic [LANES-1:0]   sce_q [STAGES];
    logic [LANES-1:0]   sce_d [STAGES];
    logic [2*LANES-1:0] te_q  [STAGES];
    logic [2*LANES-1:0] te_d  [STAGES];
    logic [LANES-1:0]   es_q  [STAGES];
    logic [LANES-1:0]   es_d  [STAGES];
    logic [TAG_W-1:0]   tag_q [STAGES];
    logic [TAG_W-1:0]   tag_d [STAGES];

    logic               rdy_s [STAGES];
    logic               rdy_acc_s;

    // Ready chain: a stage can take new content if it is empty or everything
    // downstream of it can move. Built from the output end with a running
    // accumulator so the array is never read while it is being written.
    always_comb begin
        rdy_acc_s = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_acc_s = rdy_acc_s | ~v_q[k];
            rdy_s[k]  = rdy_acc_s;
        end
    end

    // Next-state for every stage: hold by default, advance when ready.
    // Data only loads when a valid transaction arrives, so bubbles leave the
    // previous payload in place and merely clear the valid bit.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            v_d[k]   = v_q[k];
            sp_d[k]  = sp_q[k];
            sce_d[k] = sce_q[k];
            te_d[k]  = te_q[k];
            es_d[k]  = es_q[k];
            tag_d[k] = tag_q[k];
        end

        if (rdy_s[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                sp_d[0]  = ent_sp_s;
                sce_d[0] = ent_sce_s;
                te_d[0]  = ent_te_s;
                es_d[0]  = ent_es_s;
                tag_d[0] = in_tag;
            end else begin
                v_d[0] = 1'b0;
            end
        end else begin
            v_d[0] = v_q[0];
        end

        for (int k = 1; k < STAGES; k++) begin
            if (rdy_s[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    sp_d[k]  = sp_q[k-1];
                    sce_d[k] = sce_q[k-1];
                    te_d[k]  = te_q[k-1];
                    es_d[k]  = es_q[k-1];
                    tag_d[k] = tag_q[k-1];
                end else begin
                    v_d[k] = 1'b0;
                end
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    // Stage registers with synchronous reset that flushes valids and payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                sp_q[k]  <= '0;
                sce_q[k] <= '0;
                te_q[k]  <= '0;
                es_q[k]  <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_d[k];
                sp_q[k]  <= sp_d[k];
                sce_q[k] <= sce_d[k];
                te_q[k]  <= te_d[k];
                es_q[k]  <= es_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: straight from the last stage registers
    // -------------------------------------------------------------------------
    assign in_ready  = rdy_s[0];
    assign out_valid = v_q[LAST];
    assign sign_P    = sp_q[LAST];
    assign sign_Ce   = sce_q[LAST];
    assign two_en    = te_q[LAST];
    assign eff_sub   = es_q[LAST];
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_fma_sign_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fma_sign_ctrl
//
// Two instances: dut_a (LANES=1, STAGES=2) for the mode sweep and latency,
// dut_b (LANES=4, STAGES=3) for multi-lane, backpressure, bubble collapse,
// mid-operation reset and random streaming against a scoreboard.
// -----------------------------------------------------------------------------
module tb_fma_sign_ctrl;

    logic clk;
    logic rst;

    // dut_a signals
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [0:0] a_sign_A, a_sign_B, a_sign_C, a_sign_P, a_sign_Ce, a_eff_sub;
    logic [1:0] a_op, a_two_en;
    logic [3:0] a_in_tag, a_out_tag;

    // dut_b signals
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0] b_sign_A, b_sign_B, b_sign_C, b_sign_P, b_sign_Ce, b_eff_sub;
    logic [7:0] b_op, b_two_en;
    logic [3:0] b_in_tag, b_out_tag;

    int chk_cnt;
    int fail_cnt;

    fma_sign_ctrl #(.LANES(1), .STAGES(2), .TAG_W(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sign_A(a_sign_A), .sign_B(a_sign_B), .sign_C(a_sign_C),
        .op(a_op), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sign_P(a_sign_P), .sign_Ce(a_sign_Ce), .two_en(a_two_en),
        .eff_sub(a_eff_sub), .out_tag(a_out_tag)
    );

    fma_sign_ctrl #(.LANES(4), .STAGES(3), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sign_A(b_sign_A), .sign_B(b_sign_B), .sign_C(b_sign_C),
        .op(b_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sign_P(b_sign_P), .sign_Ce(b_sign_Ce), .two_en(b_two_en),
        .eff_sub(b_eff_sub), .out_tag(b_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report a mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // dut_a packed output view: {valid, tag, P, Ce, two_en, eff_sub}
    function automatic logic [31:0] pack_a();
        return {22'd0, a_out_valid, a_out_tag, a_sign_P, a_sign_Ce, a_two_en, a_eff_sub};
    endfunction

    // dut_b packed output view: {tag, P, Ce, two_en, eff_sub}
    function automatic logic [31:0] pack_b();
        return {8'd0, b_out_tag, b_sign_P, b_sign_Ce, b_two_en, b_eff_sub};
    endfunction

    // Reference for a 4-lane transaction, written from the mode table.
    function automatic logic [31:0] model_b(input logic [3:0] tag, input logic [3:0] sa,
                                            input logic [3:0] sb, input logic [3:0] sc,
                                            input logic [7:0] m);
        logic [3:0] p, ce;
        logic [7:0] te;
        for (int i = 0; i < 4; i++) begin
            p[i]       = sa[i] ^ sb[i] ^ m[2*i+1];
            ce[i]      = sc[i] ^ m[2*i];
            te[2*i+1]  = ce[i];
            te[2*i]    = p[i];
        end
        return {8'd0, tag, p, ce, te, p ^ ce};
    endfunction

    task automatic drive_b(input logic v, input logic [3:0] tag, input logic [3:0] sa,
                           input logic [3:0] sb, input logic [3:0] sc, input logic [7:0] m);
        b_in_valid = v;
        b_in_tag   = tag;
        b_sign_A   = sa;
        b_sign_B   = sb;
        b_sign_C   = sc;
        b_op       = m;
    endtask

    logic [31:0] sb_q [$];
    logic [31:0] exp_w;
    logic [31:0] prev_w;
    logic        hold;
    logic        exp_rdy;
    logic [4:0]  vec;
    logic        ep, ec;

    initial begin
        chk_cnt  = 0;
        fail_cnt = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_sign_A = '0; a_sign_B = '0;
        a_sign_C = '0; a_op = '0; a_in_tag = '0;
        drive_b(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
        b_out_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_a_out", pack_a(), 32'd0);
        check_val("rst_a_rdy", {31'd0, a_in_ready}, 32'd1);
        check_val("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
        check_val("rst_b_out", pack_b(), 32'd0);
        check_val("rst_b_rdy", {31'd0, b_in_ready}, 32'd1);

        // ---------------- mode sweep on dut_a, 2-cycle latency ----------------
        for (int j = 0; j < 34; j++) begin
            @(negedge clk);
            vec = 5'(j);
            a_in_valid = (j < 32);
            {a_sign_A, a_sign_B, a_sign_C, a_op} = vec;
            a_in_tag = vec[3:0];
            #1;
            check_val("sweep_rdy", {31'd0, a_in_ready}, 32'd1);
            if (j >= 2) begin
                vec = 5'(j - 2);
                ep  = vec[4] ^ vec[3] ^ vec[1];
                ec  = vec[2] ^ vec[0];
                exp_w = {22'd0, 1'b1, vec[3:0], ep, ec, ec, ep, ep ^ ec};
                check_val("sweep_out", pack_a(), exp_w);
                if (j - 2 == 16) check_val("sweep_a1b0c0op00", pack_a(), {22'd0, 10'b1_0000_1_0_01_1});
                if (j - 2 == 27) check_val("sweep_a1b1c0op11", pack_a(), {22'd0, 10'b1_1011_1_1_11_0});
            end
        end
        a_in_valid = 1'b0;

        // ---------------- multi-lane on dut_b, 3-cycle latency ----------------
        @(negedge clk);
        drive_b(1'b1, 4'hA, 4'b0101, 4'b0000, 4'b0011, 8'b00_01_10_11);
        @(negedge clk);
        drive_b(1'b1, 4'hB, 4'b1100, 4'b1010, 4'b0101, 8'b11_10_01_00);
        @(negedge clk);
        drive_b(1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 8'd0);
        #1;
        check_val("lane_not_yet", {31'd0, b_out_valid}, 32'd0);
        @(negedge clk); #1;
        check_val("lane_v1", {31'd0, b_out_valid}, 32'd1);
        check_val("lane_vec1", pack_b(), {8'd0, 4'hA, 4'b0110, 4'b0110, 8'b00_11_11_00, 4'b0000});
        @(negedge clk); #1;
        check_val("lane_v2", {31'd0, b_out_valid}, 32'd1);
        check_val("lane_vec2", pack_b(), {8'd0, 4'hB, 4'b1010, 4'b1111, 8'b11_10_11_10, 4'b0101});
        @(negedge clk); #1;
        check_val("lane_drained", {31'd0, b_out_valid}, 32'd0);

        // ---------------- backpressure fill / drain ----------------
        b_out_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            drive_b(1'b1, 4'(t), 4'd0, 4'd0, 4'd0, 8'd0);
            #1;
            check_val("fill_rdy", {31'd0, b_in_ready}, 32'd1);
        end
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            drive_b(1'b1, 4'd4, 4'd0, 4'd0, 4'd0, 8'd0);
            #1;
            check_val("full_rdy", {31'd0, b_in_ready}, 32'd0);
            check_val("full_valid", {31'd0, b_out_valid}, 32'd1);
            check_val("full_tag", {28'd0, b_out_tag}, 32'd1);
        end
        for (int d = 0; d < 5; d++) begin
            @(negedge clk);
            b_out_ready = 1'b1;
            if (d > 0) b_in_valid = 1'b0;
            #1;
            if (d == 0) check_val("release_rdy", {31'd0, b_in_ready}, 32'd1);
            check_val("drain_valid", {31'd0, b_out_valid}, (d < 4) ? 32'd1 : 32'd0);
            if (d < 4) check_val("drain_tag", {28'd0, b_out_tag}, 32'(d + 1));
        end

        // ---------------- bubble collapse ----------------
        b_out_ready = 1'b0;
        @(negedge clk); drive_b(1'b1, 4'd5, 4'd0, 4'd0, 4'd0, 8'd0); #1;
        check_val("bub_rdy5", {31'd0, b_in_ready}, 32'd1);
        @(negedge clk); b_in_valid = 1'b0; #1;
        check_val("bub_rdy_idle", {31'd0, b_in_ready}, 32'd1);
        @(negedge clk); drive_b(1'b1, 4'd6, 4'd0, 4'd0, 4'd0, 8'd0); #1;
        check_val("bub_rdy6", {31'd0, b_in_ready}, 32'd1);
        @(negedge clk); b_in_valid = 1'b0; #1;
        check_val("bub_head", {27'd0, b_out_valid, b_out_tag}, {27'd0, 1'b1, 4'd5});
        check_val("bub_rdy_two", {31'd0, b_in_ready}, 32'd1);
        @(negedge clk); drive_b(1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 8'd0); #1;
        check_val("bub_rdy7", {31'd0, b_in_ready}, 32'd1);
        @(negedge clk); drive_b(1'b1, 4'd8, 4'd0, 4'd0, 4'd0, 8'd0); #1;
        check_val("bub_full", {31'd0, b_in_ready}, 32'd0);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            b_in_valid = 1'b0;
            b_out_ready = 1'b1;
            #1;
            check_val("bub_drain_valid", {31'd0, b_out_valid}, (d < 3) ? 32'd1 : 32'd0);
            if (d < 3) check_val("bub_drain_tag", {28'd0, b_out_tag}, 32'(d + 5));
        end

        // ---------------- mid-operation reset ----------------
        @(negedge clk); drive_b(1'b1, 4'd9, 4'hF, 4'h0, 4'hF, 8'hFF);
        @(negedge clk); drive_b(1'b1, 4'd10, 4'hF, 4'h0, 4'hF, 8'hFF);
        @(negedge clk); drive_b(1'b1, 4'd11, 4'hF, 4'h0, 4'hF, 8'hFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b_in_valid = 1'b0;
        #1;
        check_val("mrst_valid", {31'd0, b_out_valid}, 32'd0);
        check_val("mrst_out", pack_b(), 32'd0);
        check_val("mrst_rdy", {31'd0, b_in_ready}, 32'd1);
        for (int d = 0; d < 5; d++) begin
            @(negedge clk); #1;
            check_val("mrst_no_stale", {31'd0, b_out_valid}, 32'd0);
        end

        // ---------------- random streaming against a scoreboard ----------------
        hold = 1'b0;
        prev_w = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (hold) begin
                check_val("stall_valid", {31'd0, b_out_valid}, 32'd1);
                check_val("stall_data", pack_b(), prev_w);
            end
            drive_b(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
                    4'($urandom), 8'($urandom));
            b_out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = b_out_ready | (sb_q.size() < 3);
            check_val("rnd_rdy", {31'd0, b_in_ready}, {31'd0, exp_rdy});
            if (b_out_valid && b_out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("rnd_extra", {31'd0, b_out_valid}, 32'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    check_val("rnd_data", pack_b(), exp_w);
                end
            end
            if (b_in_valid && b_in_ready)
                sb_q.push_back(model_b(b_in_tag, b_sign_A, b_sign_B, b_sign_C, b_op));
            hold   = b_out_valid & ~b_out_ready;
            prev_w = pack_b();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int d = 0; d < 8; d++) begin
            @(negedge clk); #1;
            if (b_out_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("drain_extra", {31'd0, b_out_valid}, 32'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    check_val("drain_data", pack_b(), exp_w);
                end
            end
        end
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
